// File: rtl/color_bar_checker.sv
// -----------------------------------------------------------------------------
// color_bar_checker
//
// Receive-side checker for the 7-bar colour test pattern. It watches the
// active-video pixel stream at the sink end of the video path and compares
// each active pixel with the bar colour expected for its column. It reports:
//   - per-line results (pass/fail, width error, first bad column),
//   - saturating error counters,
//   - a pattern-lock status.
//
// Bar layout: there are 7 bars of BW = DISPLAY_WIDTH/7 pixels each. The last
// bar also takes any remainder columns.
//
// Ports
//   pixel_clk      in   pixel clock, all logic on the rising edge
//   n_rst          in   asynchronous active-low reset
//   active_video   in   high while red/green/blue carry an active pixel
//   red/green/blue in   8-bit colour components
//   clr_err        in   synchronous clear of both error counters
//   line_done      out  one-cycle pulse when the line result outputs update
//   line_ok        out  last line had the correct width and no mismatches
//   width_err      out  last line pixel count differed from DISPLAY_WIDTH
//   first_err_col  out  first mismatching column of last line (DISPLAY_WIDTH if none)
//   locked         out  LOCK_LINES consecutive good lines seen
//   err_pix_count  out  total mismatched pixels, saturating
//   bad_line_count out  total failed lines, saturating
// -----------------------------------------------------------------------------
module color_bar_checker #(
    parameter  int DISPLAY_WIDTH = 640,
    parameter  int LOCK_LINES    = 4,
    parameter  int ERR_CNT_WIDTH = 16,
    localparam int CW            = $clog2(DISPLAY_WIDTH + 1)
) (
    input  logic                     pixel_clk,
    input  logic                     n_rst,
    input  logic                     active_video,
    input  logic [7:0]               red,
    input  logic [7:0]               green,
    input  logic [7:0]               blue,
    input  logic                     clr_err,
    output logic                     line_done,
    output logic                     line_ok,
    output logic                     width_err,
    output logic [CW-1:0]            first_err_col,
    output logic                     locked,
    output logic [ERR_CNT_WIDTH-1:0] err_pix_count,
    output logic [ERR_CNT_WIDTH-1:0] bad_line_count
);

    localparam int            BW      = DISPLAY_WIDTH / 7;
    localparam int            BPW     = $clog2(BW + 1);
    localparam int            RW      = $clog2(LOCK_LINES + 1);
    localparam logic [CW-1:0] C_WIDTH = CW'(DISPLAY_WIDTH);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ACQ,
        S_LOCKED
    } state_t;

    // Colour of bar k as {R,G,B}. Bar 6 is the default, so it also covers
    // any unused index value.
    function automatic logic [23:0] bar_colour(input logic [2:0] k);
        case (k)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            default: return 24'h0000FF;
        endcase
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_WIDTH'(1);
    endfunction

    logic                     r_armed;
    logic                     r_av_d;
    logic [CW-1:0]            r_col;
    logic                     r_over;
    logic [2:0]               r_bar;
    logic [BPW-1:0]           r_bar_pos;
    logic                     r_line_mis;
    logic [CW-1:0]            r_first_col;
    logic                     r_line_done;
    logic                     r_line_ok;
    logic                     r_width_err;
    logic [CW-1:0]            r_first_err_col;
    logic [ERR_CNT_WIDTH-1:0] r_err_pix;
    logic [ERR_CNT_WIDTH-1:0] r_bad_line;
    state_t                   r_state;
    logic [RW-1:0]            r_run;

    logic                     w_pix_act;
    logic                     w_eol;
    logic                     w_pix_mis;
    logic                     w_width_bad;
    logic                     w_line_good;
    state_t                   w_state_nxt;
    logic [RW-1:0]            w_run_nxt;

    assign w_pix_act   = r_armed & active_video;
    assign w_eol       = r_armed & ~active_video & r_av_d;
    // A pixel past DISPLAY_WIDTH is never compared. It only sets r_over.
    assign w_pix_mis   = w_pix_act & (r_col < C_WIDTH) &
                         ({red, green, blue} != bar_colour(r_bar));
    assign w_width_bad = r_over | (r_col != C_WIDTH);
    assign w_line_good = ~w_width_bad & ~r_line_mis;

    // The expected bar is tracked incrementally (bar index + position in
    // bar), so no divider is needed. The bar index stops at 6, which lets
    // the last bar absorb the remainder columns.
    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_armed     <= 1'b0;
            r_av_d      <= 1'b0;
            r_col       <= '0;
            r_over      <= 1'b0;
            r_bar       <= '0;
            r_bar_pos   <= '0;
            r_line_mis  <= 1'b0;
            r_first_col <= '0;
        end else begin
            r_av_d <= active_video;
            // Ignore everything until the first blanking sample, so a line
            // already in progress at reset release is never judged.
            if (!r_armed && !active_video) begin
                r_armed <= 1'b1;
            end
            if (w_eol) begin
                r_col       <= '0;
                r_over      <= 1'b0;
                r_bar       <= '0;
                r_bar_pos   <= '0;
                r_line_mis  <= 1'b0;
                r_first_col <= '0;
            end else if (w_pix_act) begin
                if (r_col == C_WIDTH) begin
                    r_over <= 1'b1;
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (r_bar != 3'd6) begin
                    if (r_bar_pos == BPW'(BW - 1)) begin
                        r_bar     <= r_bar + 3'd1;
                        r_bar_pos <= '0;
                    end else begin
                        r_bar_pos <= r_bar_pos + BPW'(1);
                    end
                end
                if (w_pix_mis && !r_line_mis) begin
                    r_line_mis  <= 1'b1;
                    r_first_col <= r_col;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_line_done     <= 1'b0;
            r_line_ok       <= 1'b0;
            r_width_err     <= 1'b0;
            r_first_err_col <= C_WIDTH;
        end else begin
            r_line_done <= w_eol;
            if (w_eol) begin
                r_line_ok       <= w_line_good;
                r_width_err     <= w_width_bad;
                r_first_err_col <= r_line_mis ? r_first_col : C_WIDTH;
            end
        end
    end

    // clr_err takes priority over an increment in the same cycle.
    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_pix  <= '0;
            r_bad_line <= '0;
        end else if (clr_err) begin
            r_err_pix  <= '0;
            r_bad_line <= '0;
        end else begin
            if (w_pix_mis) begin
                r_err_pix <= sat_inc(r_err_pix);
            end
            if (w_eol && !w_line_good) begin
                r_bad_line <= sat_inc(r_bad_line);
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_SEARCH;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // The lock FSM only moves on an end-of-line cycle. r_run counts
    // consecutive good lines.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (w_eol) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_line_good) begin
                        w_run_nxt   = RW'(1);
                        w_state_nxt = (LOCK_LINES == 1) ? S_LOCKED : S_ACQ;
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                S_ACQ: begin
                    if (w_line_good) begin
                        w_run_nxt = r_run + RW'(1);
                        if ((r_run + RW'(1)) == RW'(LOCK_LINES)) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_run_nxt   = '0;
                        w_state_nxt = S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    if (!w_line_good) begin
                        w_run_nxt   = '0;
                        w_state_nxt = S_SEARCH;
                    end
                end
                default: begin
                    w_run_nxt   = '0;
                    w_state_nxt = S_SEARCH;
                end
            endcase
        end
    end

    assign line_done      = r_line_done;
    assign line_ok        = r_line_ok;
    assign width_err      = r_width_err;
    assign first_err_col  = r_first_err_col;
    assign locked         = (r_state == S_LOCKED);
    assign err_pix_count  = r_err_pix;
    assign bad_line_count = r_bad_line;

endmodule

// File: tb/tb_color_bar_checker.sv
// -----------------------------------------------------------------------------
// tb_color_bar_checker
//
// Testbench for color_bar_checker. Two checkers share one pixel stream:
//   - dut  uses 16-bit error counters,
//   - dut4 uses 4-bit error counters, so counter saturation shows up quickly.
//
// Expected results come from a line-level reference model:
//   - the expected colour of each column uses direct integer division,
//   - lock status is "at least LOCK_LINES consecutive good lines".
// -----------------------------------------------------------------------------
module tb_color_bar_checker;

    localparam int DW = 640;
    localparam int LL = 4;
    localparam int CW = $clog2(DW + 1);
    localparam int BW = DW / 7;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          av = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    red = '0, green = '0, blue = '0;

    logic          ld, ok, werr, lock;
    logic [CW-1:0] fcol;
    logic [15:0]   epc, blc;
    logic          ld4, ok4, werr4, lock4;
    logic [CW-1:0] fcol4;
    logic [3:0]    epc4, blc4;

    color_bar_checker #(.DISPLAY_WIDTH(DW), .LOCK_LINES(LL), .ERR_CNT_WIDTH(16)) dut (
        .pixel_clk(clk), .n_rst(n_rst), .active_video(av),
        .red(red), .green(green), .blue(blue), .clr_err(clr),
        .line_done(ld), .line_ok(ok), .width_err(werr), .first_err_col(fcol),
        .locked(lock), .err_pix_count(epc), .bad_line_count(blc)
    );

    color_bar_checker #(.DISPLAY_WIDTH(DW), .LOCK_LINES(LL), .ERR_CNT_WIDTH(4)) dut4 (
        .pixel_clk(clk), .n_rst(n_rst), .active_video(av),
        .red(red), .green(green), .blue(blue), .clr_err(clr),
        .line_done(ld4), .line_ok(ok4), .width_err(werr4), .first_err_col(fcol4),
        .locked(lock4), .err_pix_count(epc4), .bad_line_count(blc4)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int n_done = 0;

    always @(negedge clk) begin
        if (ld) n_done++;
    end

    // Reference model state
    int            m_epc = 0, m_blc = 0, m_run = 0, m_done = 0;
    logic          m_ok, m_werr;
    logic [CW-1:0] m_fcol;
    logic [23:0]   line_px [0:1023];

    // Values captured at the line_done sample point
    logic          g_done, g_done2, g_ok, g_werr, g_lock;
    logic          g4_done, g4_ok, g4_werr, g4_lock;
    logic [CW-1:0] g_fcol, g4_fcol;
    logic [15:0]   g_epc, g_blc, g_clr16;
    logic [3:0]    g_epc4, g_blc4, g_clr4;

    function automatic logic [23:0] exp_col(input int c);
        int k;
        k = (c < 6 * BW) ? c / BW : 6;
        case (k)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            default: return 24'h0000FF;
        endcase
    endfunction

    function automatic logic [15:0] sat16(input int x);
        return (x > 65535) ? 16'hFFFF : 16'(x);
    endfunction

    function automatic logic [3:0] sat4(input int x);
        return (x > 15) ? 4'hF : 4'(x);
    endfunction

    // Fill line_px with the correct pattern, then corrupt nerr distinct
    // in-range columns. A stride of 29 keeps the chosen columns distinct.
    task automatic build_line(input int npix, input int nerr);
        int lim, off;
        lim = (npix < DW) ? npix : DW;
        for (int c = 0; c < npix; c++)
            line_px[c] = (c < DW) ? exp_col(c) : 24'($urandom);
        off = $urandom_range(lim - 1, 0);
        for (int k = 0; k < nerr; k++) begin
            int c;
            c = (off + k * 29) % lim;
            line_px[c] = line_px[c] ^ (24'($urandom) | 24'h000001);
        end
    endtask

    // Drive line_px as one line, then blanking. The task also updates the
    // model and captures DUT outputs one cycle after the first blank sample.
    // clr_at >= 0 asserts clr_err together with that pixel.
    task automatic drive_line(input int npix, input int nblank, input int clr_at);
        int mis, first;
        mis = 0;
        first = DW;
        for (int c = 0; c < npix; c++) begin
            @(negedge clk);
            if (clr_at >= 0 && c == clr_at + 1) begin
                g_clr16 = epc;
                g_clr4  = epc4;
            end
            av = 1'b1;
            {red, green, blue} = line_px[c];
            clr = (c == clr_at);
            if (c < DW && line_px[c] != exp_col(c)) begin
                mis++;
                if (first == DW) first = c;
                if (c != clr_at) m_epc++;
            end
            if (c == clr_at) begin
                m_epc = 0;
                m_blc = 0;
            end
        end
        @(negedge clk);
        av = 1'b0;
        clr = 1'b0;
        {red, green, blue} = 24'h0;
        @(negedge clk);
        g_done = ld;   g_ok = ok;   g_werr = werr;   g_fcol = fcol;   g_lock = lock;
        g4_done = ld4; g4_ok = ok4; g4_werr = werr4; g4_fcol = fcol4; g4_lock = lock4;
        g_epc = epc; g_blc = blc; g_epc4 = epc4; g_blc4 = blc4;
        m_werr = (npix != DW);
        m_ok   = !m_werr && (mis == 0);
        m_fcol = CW'(first);
        if (!m_ok) m_blc++;
        m_run = m_ok ? m_run + 1 : 0;
        m_done++;
        @(negedge clk);
        g_done2 = ld;
        repeat (nblank - 2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; av = 1'b0; clr = 1'b0; {red, green, blue} = 24'h0;
        repeat (3) @(negedge clk);
        nvec++; if (ld !== 1'b0) begin nfail++; $display("FAIL rst_line_done got %b want 0", ld); end
        nvec++; if (ok !== 1'b0) begin nfail++; $display("FAIL rst_line_ok got %b want 0", ok); end
        nvec++; if (werr !== 1'b0) begin nfail++; $display("FAIL rst_width_err got %b want 0", werr); end
        nvec++; if (fcol !== CW'(DW)) begin nfail++; $display("FAIL rst_first_err_col got %0d want %0d", fcol, DW); end
        nvec++; if (lock !== 1'b0) begin nfail++; $display("FAIL rst_locked got %b want 0", lock); end
        nvec++; if (epc !== 16'd0 || blc !== 16'd0 || epc4 !== 4'd0 || blc4 !== 4'd0) begin
            nfail++; $display("FAIL rst_counters got %0d/%0d/%0d/%0d want 0", epc, blc, epc4, blc4); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        m_epc = 0; m_blc = 0; m_run = 0;
    endtask

    task automatic test_good_lines();
        for (int i = 0; i < 5; i++) begin
            build_line(DW, 0);
            drive_line(DW, 16, -1);
            nvec++; if (g_done !== 1'b1 || g_done2 !== 1'b0) begin nfail++; $display("FAIL good_pulse line %0d got %b%b want 10", i, g_done, g_done2); end
            nvec++; if (g_ok !== 1'b1) begin nfail++; $display("FAIL good_line_ok line %0d got %b want 1", i, g_ok); end
            nvec++; if (g_fcol !== CW'(DW)) begin nfail++; $display("FAIL good_first_col line %0d got %0d want %0d", i, g_fcol, DW); end
            nvec++; if (g_lock !== (i >= LL - 1)) begin nfail++; $display("FAIL good_locked line %0d got %b want %b", i, g_lock, i >= LL - 1); end
            nvec++; if (g_epc !== 16'd0 || g_blc !== 16'd0) begin nfail++; $display("FAIL good_counters line %0d got %0d/%0d want 0/0", i, g_epc, g_blc); end
        end
    endtask

    task automatic test_mismatch();
        build_line(DW, 0);
        line_px[91] = 24'hFFFFFF;
        drive_line(DW, 16, -1);
        nvec++; if (g_ok !== 1'b0) begin nfail++; $display("FAIL mis_line_ok got %b want 0", g_ok); end
        nvec++; if (g_fcol !== CW'(91)) begin nfail++; $display("FAIL mis_first_col got %0d want 91", g_fcol); end
        nvec++; if (g_epc !== 16'd1 || g_epc4 !== 4'd1) begin nfail++; $display("FAIL mis_err_pix got %0d/%0d want 1", g_epc, g_epc4); end
        nvec++; if (g_blc !== 16'd1) begin nfail++; $display("FAIL mis_bad_line got %0d want 1", g_blc); end
        nvec++; if (g_lock !== 1'b0) begin nfail++; $display("FAIL mis_locked got %b want 0", g_lock); end
    endtask

    task automatic test_width();
        build_line(DW - 1, 0);
        drive_line(DW - 1, 16, -1);
        nvec++; if (g_werr !== 1'b1 || g_ok !== 1'b0) begin nfail++; $display("FAIL short_width got werr=%b ok=%b want 1 0", g_werr, g_ok); end
        nvec++; if (g_epc !== 16'd1) begin nfail++; $display("FAIL short_err_pix got %0d want 1", g_epc); end
        nvec++; if (g_blc !== 16'd2) begin nfail++; $display("FAIL short_bad_line got %0d want 2", g_blc); end
        nvec++; if (g_fcol !== CW'(DW)) begin nfail++; $display("FAIL short_first_col got %0d want %0d", g_fcol, DW); end
        build_line(DW, 0);
        drive_line(DW, 16, -1);
        nvec++; if (g_werr !== 1'b0 || g_ok !== 1'b1) begin nfail++; $display("FAIL after_short got werr=%b ok=%b want 0 1", g_werr, g_ok); end
        build_line(DW + 1, 0);
        drive_line(DW + 1, 16, -1);
        nvec++; if (g_werr !== 1'b1 || g_ok !== 1'b0 || g_epc !== 16'd1) begin
            nfail++; $display("FAIL long_width got werr=%b ok=%b epc=%0d want 1 0 1", g_werr, g_ok, g_epc); end
    endtask

    task automatic test_acq_drop();
        build_line(DW, 3);
        drive_line(DW, 10, -1);
        nvec++; if (g_lock !== 1'b0 || g_ok !== 1'b0) begin nfail++; $display("FAIL acq_bad0 got lock=%b ok=%b want 0 0", g_lock, g_ok); end
        for (int i = 0; i < 3; i++) begin
            build_line(DW, 0);
            drive_line(DW, 10, -1);
            nvec++; if (g_lock !== 1'b0) begin nfail++; $display("FAIL acq_run%0d locked got %b want 0", i, g_lock); end
        end
        build_line(DW, 1);
        drive_line(DW, 10, -1);
        nvec++; if (g_lock !== 1'b0 || g_ok !== 1'b0) begin nfail++; $display("FAIL acq_drop got lock=%b ok=%b want 0 0", g_lock, g_ok); end
        for (int i = 0; i < 4; i++) begin
            build_line(DW, 0);
            drive_line(DW, 10, -1);
            nvec++; if (g_lock !== (i == 3)) begin nfail++; $display("FAIL acq_relock%0d locked got %b want %b", i, g_lock, i == 3); end
        end
        nvec++; if (g_blc !== sat16(m_blc) || g_blc4 !== sat4(m_blc)) begin
            nfail++; $display("FAIL acq_bad_line got %0d/%0d want %0d", g_blc, g_blc4, m_blc); end
    endtask

    task automatic test_reset_midline();
        int done0;
        for (int c = 0; c < DW; c++) begin
            @(negedge clk);
            av = 1'b1;
            {red, green, blue} = (c >= 350 && c < 360) ? ~exp_col(c) : exp_col(c);
            if (c == 200) begin
                n_rst = 1'b0;
                #1;
                nvec++; if (lock !== 1'b0 || blc !== 16'd0 || fcol !== CW'(DW) || ok !== 1'b0) begin
                    nfail++; $display("FAIL async_clear got lock=%b blc=%0d fcol=%0d ok=%b want 0 0 %0d 0", lock, blc, fcol, ok, DW); end
            end
            if (c == 300) begin
                done0 = n_done;
                n_rst = 1'b1;
            end
        end
        @(negedge clk);
        av = 1'b0;
        {red, green, blue} = 24'h0;
        repeat (16) @(negedge clk);
        nvec++; if (n_done !== done0) begin nfail++; $display("FAIL partial_no_done got %0d pulses want %0d", n_done, done0); end
        nvec++; if (epc !== 16'd0 || blc !== 16'd0) begin nfail++; $display("FAIL partial_no_err got %0d/%0d want 0/0", epc, blc); end
        m_epc = 0; m_blc = 0; m_run = 0;
        build_line(DW, 0);
        drive_line(DW, 16, -1);
        nvec++; if (g_done !== 1'b1 || g_ok !== 1'b1) begin nfail++; $display("FAIL rearm_line got done=%b ok=%b want 1 1", g_done, g_ok); end
        nvec++; if (g_epc !== 16'd0 || g_blc !== 16'd0) begin nfail++; $display("FAIL rearm_counters got %0d/%0d want 0/0", g_epc, g_blc); end
    endtask

    task automatic test_saturate_clr();
        build_line(DW, 20);
        drive_line(DW, 16, -1);
        nvec++; if (g_epc4 !== 4'hF) begin nfail++; $display("FAIL sat_err_pix4 got %0d want 15", g_epc4); end
        nvec++; if (g_epc !== sat16(m_epc)) begin nfail++; $display("FAIL sat_err_pix16 got %0d want %0d", g_epc, m_epc); end
        build_line(DW, 30);
        if (line_px[100] == exp_col(100)) line_px[100] = ~exp_col(100);
        drive_line(DW, 16, 100);
        nvec++; if (g_clr16 !== 16'd0 || g_clr4 !== 4'd0) begin nfail++; $display("FAIL clr_wins got %0d/%0d want 0", g_clr16, g_clr4); end
        nvec++; if (g_epc !== sat16(m_epc) || g_epc4 !== sat4(m_epc)) begin
            nfail++; $display("FAIL clr_err_pix got %0d/%0d want %0d", g_epc, g_epc4, m_epc); end
        nvec++; if (g_blc !== 16'd1) begin nfail++; $display("FAIL clr_bad_line got %0d want 1", g_blc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int sel, npix, nerr, clr_at;
            sel = $urandom_range(9, 0);
            npix = (sel == 6) ? DW - 1 : (sel == 7) ? DW + 1 : (sel == 8) ? 600 : (sel == 9) ? 700 : DW;
            nerr = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(25, 1);
            clr_at = ($urandom_range(9, 0) == 0) ? $urandom_range(npix - 2, 0) : -1;
            build_line(npix, nerr);
            drive_line(npix, $urandom_range(20, 2), clr_at);
            nvec++; if (g_done !== 1'b1 || g_done2 !== 1'b0 || g4_done !== 1'b1) begin
                nfail++; $display("FAIL rnd_pulse line %0d got %b%b want 10", i, g_done, g_done2); end
            nvec++; if (g_ok !== m_ok || g4_ok !== m_ok) begin nfail++; $display("FAIL rnd_line_ok line %0d got %b/%b want %b", i, g_ok, g4_ok, m_ok); end
            nvec++; if (g_werr !== m_werr || g4_werr !== m_werr) begin nfail++; $display("FAIL rnd_width_err line %0d got %b want %b", i, g_werr, m_werr); end
            nvec++; if (g_fcol !== m_fcol || g4_fcol !== m_fcol) begin nfail++; $display("FAIL rnd_first_col line %0d got %0d want %0d", i, g_fcol, m_fcol); end
            nvec++; if (g_lock !== (m_run >= LL) || g4_lock !== (m_run >= LL)) begin
                nfail++; $display("FAIL rnd_locked line %0d got %b want %b", i, g_lock, m_run >= LL); end
            nvec++; if (g_epc !== sat16(m_epc) || g_epc4 !== sat4(m_epc)) begin
                nfail++; $display("FAIL rnd_err_pix line %0d got %0d/%0d want %0d", i, g_epc, g_epc4, m_epc); end
            nvec++; if (g_blc !== sat16(m_blc) || g_blc4 !== sat4(m_blc)) begin
                nfail++; $display("FAIL rnd_bad_line line %0d got %0d/%0d want %0d", i, g_blc, g_blc4, m_blc); end
            if (clr_at >= 0) begin
                nvec++; if (g_clr16 !== 16'd0 || g_clr4 !== 4'd0) begin
                    nfail++; $display("FAIL rnd_clr line %0d got %0d/%0d want 0", i, g_clr16, g_clr4); end
            end
        end
    endtask

    initial begin
        int done_base;
        test_reset();
        done_base = n_done;
        m_done = 0;
        test_good_lines();
        test_mismatch();
        test_width();
        test_acq_drop();
        nvec++; if (n_done - done_base !== m_done) begin
            nfail++; $display("FAIL pulse_count got %0d want %0d", n_done - done_base, m_done); end
        test_reset_midline();
        test_saturate_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
